// File: rtl/beat_note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : beat_note_recorder
// Description : Captures the player's note switches once per beat into a
//               2**ADDR_W-word note memory. Switch activity is OR-accumulated
//               while record_high is asserted and committed on each beat.
//               Provides a registered read port for the playback stage and
//               recording / full / length / wr_addr status.
//
// Ports       : clk         - system clock
//               resetn      - asynchronous active-low reset
//               start       - pulse: (re)start recording, clears position
//               stop        - pulse: end recording
//               beat        - pulse: commit accumulated notes to memory
//               record_high - sampling window for note accumulation
//               notes       - live note switches (DATA_W bits)
//               rd_addr     - playback read address
//               rd_data     - registered read data (1-cycle latency)
//               recording   - high while in REC
//               full        - high when length == 2**ADDR_W
//               length      - words written since start (0..2**ADDR_W)
//               wr_addr     - next write slot
//
// Options     : BEAT_REC_LOOP_EN - when defined, recording continues past a
//               full memory, overwriting the oldest words; length saturates.
//
// Revision    : 1.0 - initial release
// ============================================================================
module beat_note_recorder #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              beat,
    input  logic              record_high,
    input  logic [DATA_W-1:0] notes,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              recording,
    output logic              full,
    output logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int              c_DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_DEPTH   = c_DEPTH_I[ADDR_W:0];
    localparam logic [ADDR_W:0] c_LAST    = c_DEPTH - (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_length;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:c_DEPTH_I-1];

    logic              w_in_rec;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;

    assign w_in_rec = (r_state == S_REC);
    // start wins over beat: a start cycle never writes memory.
    assign w_wr_en   = w_in_rec & beat & ~start;
    // Notes present on the beat cycle itself still count if inside the window.
    assign w_wr_data = r_acc | (record_high ? notes : '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_REC;
            end
            S_REC: begin
                if (start) begin
                    w_state_nxt = S_REC;
                end else if (stop) begin
                    w_state_nxt = S_DONE;
                end
`ifdef BEAT_REC_LOOP_EN
                // Looping mode: a full memory keeps recording over old words.
`else
                else if (beat && (r_length == c_LAST)) begin
                    w_state_nxt = S_DONE;
                end
`endif
            end
            S_DONE: begin
                if (start) w_state_nxt = S_REC;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write pointer, length and note accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_addr <= '0;
            r_length  <= '0;
            r_acc     <= '0;
        end else if (start) begin
            r_wr_addr <= '0;
            r_length  <= '0;
            r_acc     <= '0;
        end else if (w_in_rec) begin
            if (beat) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
`ifdef BEAT_REC_LOOP_EN
                if (r_length != c_DEPTH) begin
                    r_length <= r_length + (ADDR_W+1)'(1);
                end
`else
                r_length <= r_length + (ADDR_W+1)'(1);
`endif
                r_acc <= '0;
            end else if (record_high) begin
                r_acc <= r_acc | notes;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Note memory: contents survive reset, so no reset on the array.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_wr_data;
        end
    end

    // Read samples the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data   = r_rd_data;
    assign recording = w_in_rec;
    assign full      = (r_length == c_DEPTH);
    assign length    = r_length;
    assign wr_addr   = r_wr_addr;

endmodule
`default_nettype wire

// File: tb/tb_beat_note_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_note_recorder
// Description : Scoreboard bench for beat_note_recorder. Stimulus pushes
//               expected read data and status into queues; a negedge monitor
//               pops and compares when a read result or status sample is due.
//               Honours BEAT_REC_LOOP_EN for the full-memory expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_note_recorder;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 10;

    logic              clk = 1'b0;
    logic              resetn;
    logic              start;
    logic              stop;
    logic              beat;
    logic              record_high;
    logic [DATA_W-1:0] notes;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              recording;
    logic              full;
    logic [ADDR_W:0]   length;
    logic [ADDR_W-1:0] wr_addr;

    beat_note_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .stop        (stop),
        .beat        (beat),
        .record_high (record_high),
        .notes       (notes),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .recording   (recording),
        .full        (full),
        .length      (length),
        .wr_addr     (wr_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    len;
        int    wa;
        bit    rec;
        bit    fl;
        bit    chk_rd;
        int    rd;
    } st_exp_t;

    typedef struct {
        string name;
        int    val;
    } rd_exp_t;

    st_exp_t st_q[$];
    rd_exp_t rd_q[$];

    int   checks = 0;
    int   errors = 0;
    logic rd_req = 1'b0;
    logic rd_vld = 1'b0;
    logic st_req = 1'b0;

    // Read data appears one edge after the address is presented.
    always @(posedge clk) rd_vld <= rd_req;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h with no expectation", rd_data);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, int'(rd_data), e.val);
            end
        end
        if (st_req) begin
            if (st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL st_unexpected: status sample with no expectation");
            end else begin
                st_exp_t s;
                s = st_q.pop_front();
                chk({s.name, ".length"},    int'(length),    s.len);
                chk({s.name, ".wr_addr"},   int'(wr_addr),   s.wa);
                chk({s.name, ".recording"}, int'(recording), int'(s.rec));
                chk({s.name, ".full"},      int'(full),      int'(s.fl));
                if (s.chk_rd) chk({s.name, ".rd_data"}, int'(rd_data), s.rd);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        beat   = 1'b0;
        rd_req = 1'b0;
        st_req = 1'b0;
    endtask

    task automatic exp_st(input string n, input int len, input int wa,
                          input bit rec, input bit fl);
        st_q.push_back('{name:n, len:len, wa:wa, rec:rec, fl:fl, chk_rd:1'b0, rd:0});
        st_req = 1'b1;
    endtask

    task automatic exp_st_rd(input string n, input int len, input int wa,
                             input bit rec, input bit fl, input int rd);
        st_q.push_back('{name:n, len:len, wa:wa, rec:rec, fl:fl, chk_rd:1'b1, rd:rd});
        st_req = 1'b1;
    endtask

    task automatic rd(input int a, input int v, input string n);
        rd_addr = ADDR_W'(a);
        rd_q.push_back('{name:n, val:v});
        rd_req = 1'b1;
    endtask

    task automatic do_beat(input int nv, input bit rh);
        notes       = DATA_W'(nv);
        record_high = rh;
        beat        = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        resetn = 1'b0; start = 1'b0; stop = 1'b0; beat = 1'b0;
        record_high = 1'b0; notes = '0; rd_addr = '0;
        step(); step();
        exp_st_rd("reset", 0, 0, 1'b0, 1'b0, 0);
        step();
        resetn = 1'b1;
        step();

        // Accumulate across the window, commit on a beat outside it.
        start = 1'b1; step();
        exp_st("start", 0, 0, 1'b1, 1'b0);
        record_high = 1'b1; notes = 10'h001; step(); step();
        notes = 10'h004; step(); step();
        record_high = 1'b0; notes = '0;
        beat = 1'b1; step();
        exp_st("beat1", 1, 1, 1'b1, 1'b0);
        step();
        rd(0, 10'h005, "mem0_acc"); step();

        // Notes outside the window are ignored; notes on the beat cycle count.
        notes = 10'h3FF; record_high = 1'b0; step(); step();
        do_beat(10'h3FF, 1'b0);
        do_beat(10'h200, 1'b1);
        record_high = 1'b0; notes = '0;
        exp_st("beat3", 3, 3, 1'b1, 1'b0);
        rd(1, 10'h000, "mem1_outside_window"); step();
        rd(2, 10'h200, "mem2_beat_cycle"); step();

        // Beat and stop together: write completes, then DONE.
        notes = 10'h0AA; record_high = 1'b1; beat = 1'b1; stop = 1'b1; step();
        record_high = 1'b0;
        exp_st("beat_stop", 4, 4, 1'b0, 1'b0);
        rd(3, 10'h0AA, "mem3_beat_stop"); step();

        // DONE ignores beat and stop.
        notes = 10'h3FF; record_high = 1'b1; beat = 1'b1; stop = 1'b1; step();
        record_high = 1'b0;
        exp_st("done_ignore", 4, 4, 1'b0, 1'b0);
        rd(3, 10'h0AA, "mem3_kept"); step();

        // Fill all 64 words with their index.
        start = 1'b1; step();
        for (int i = 0; i < 64; i++) begin
            do_beat(i, 1'b1);
            if (i == 62) exp_st("len63", 63, 63, 1'b1, 1'b0);
        end
        record_high = 1'b0;
`ifdef BEAT_REC_LOOP_EN
        exp_st("full64", 64, 0, 1'b1, 1'b1);
`else
        exp_st("full64", 64, 0, 1'b0, 1'b1);
`endif
        rd(63, 63, "mem63"); step();
        do_beat(64, 1'b1);
        record_high = 1'b0;
`ifdef BEAT_REC_LOOP_EN
        exp_st("beat65", 64, 1, 1'b1, 1'b1);
        rd(0, 64, "mem0_beat65"); step();
`else
        exp_st("beat65", 64, 0, 1'b0, 1'b1);
        rd(0, 0, "mem0_beat65"); step();
`endif
        rd(10, 10, "mem10_filled"); step();

        // start and beat together at length 10: restart, no write.
        start = 1'b1; step();
        for (int i = 0; i < 10; i++) do_beat(10'h100 + i, 1'b1);
        record_high = 1'b0;
        exp_st("len10", 10, 10, 1'b1, 1'b0);
        step();
        start = 1'b1; beat = 1'b1; record_high = 1'b1; notes = 10'h3FF; step();
        record_high = 1'b0; notes = '0;
        exp_st("start_beat", 0, 0, 1'b1, 1'b0);
        rd(10, 10, "mem10_no_write"); step();
        rd(9, 10'h109, "mem9"); step();
        do_beat(0, 1'b0);
        exp_st("after_restart", 1, 1, 1'b1, 1'b0);
        step();
        rd(0, 0, "mem0_acc_cleared"); step();

        // Asynchronous reset in the middle of a recording.
        start = 1'b1; step();
        for (int i = 0; i < 5; i++) do_beat(i + 1, 1'b1);
        record_high = 1'b0;
        exp_st("len5", 5, 5, 1'b1, 1'b0);
        rd(4, 5, "mem4"); step();
        step();
        resetn = 1'b0;
        exp_st_rd("async_reset", 0, 0, 1'b0, 1'b0, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        start = 1'b1; step();
        exp_st("start_after_reset", 0, 0, 1'b1, 1'b0);
        rd(4, 5, "mem4_survives_reset"); step();

        begin
            int k = 0;
            while ((rd_q.size() != 0 || st_q.size() != 0) && k < 20) begin
                step();
                k++;
            end
        end
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0",
                     rd_q.size() + st_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
